id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- Instruction-decode stage plus the ID/EX pipeline register for the 5-stage MIPS pipeline.
- Drives the register-file read addresses (rs/rt) and receives the read data.
- Applies WB→ID same-cycle bypass, decodes control, and detects load-use hazards (stall + bubble).
- Registers everything for the EX stage. Also honours branch flush and counts stall cycles.

Parameters:
- STALL_CNT_W, 16, width of the saturating stall-cycle counter.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  reset; asynchronous, active-low.
- id_valid  in  1  IF/ID holds a valid instruction.
- id_instr  in  32  instruction from IF/ID.
- id_pc4  in  32  PC+4 from IF/ID.
- rn1  out  5  register-file read address, port 1 (= id_instr[25:21]); combinational.
- rn2  out  5  register-file read address, port 2 (= id_instr[20:16]); combinational.
- rd1  in  32  register-file read data, port 1.
- rd2  in  32  register-file read data, port 2.
- wb_regwrite  in  1  WB-stage write enable.
- wb_wn  in  5  WB-stage destination register.
- wb_wd  in  32  WB-stage write data.
- flush  in  1  branch-taken flush from EX.
- stall  out  1  hold PC and IF/ID this cycle; combinational.
- ex_valid  out  1  ID/EX holds a real instruction.
- ex_rd1, ex_rd2  out  32  operand values.
- ex_imm  out  32  sign-extended id_instr[15:0].
- ex_rs, ex_rt, ex_rd  out  5  register fields.
- ex_pc4  out  32  PC+4.
- ex_regdst, ex_alusrc, ex_memread, ex_memwrite, ex_regwrite, ex_memtoreg, ex_branch  out  1 each  control bits.
- ex_aluop  out  2  00 add, 01 sub, 10 funct-decoded.
- ex_illegal  out  1  one-cycle flag: undefined opcode was consumed.
- stall_cnt  out  STALL_CNT_W  saturating count of stall cycles.

Behaviour:
- Reset (async, rst_n=0): every ex_* output, ex_illegal and stall_cnt go to 0 immediately and stay 0 until the first posedge after release.
- Decode, by opcode id_instr[31:26]:
  - 000000 R-type: regdst=1, regwrite=1, aluop=10.
  - 100011 lw: alusrc=1, memread=1, memtoreg=1, regwrite=1, aluop=00.
  - 101011 sw: alusrc=1, memwrite=1, aluop=00.
  - 000100 beq: branch=1, aluop=01.
  - 001000 addi: alusrc=1, regwrite=1, aluop=00.
  - id_instr==0 (nop): bubble, not illegal.
  - Any other opcode: bubble with ex_illegal=1 for one cycle.
- Bubble: ex_valid=0 and all control bits 0. Data fields are don't-care but are loaded deterministically.
- Operand bypass:
  - op1 = wb_wd if wb_regwrite && wb_wn!=0 && wb_wn==rn1; else 0 if rn1==0; else rd1.
  - op2 is the same rule applied to rn2/rd2.
  - This covers the same-edge write in the register file.
- Load-use stall: stall = id_valid && ex_valid && ex_memread && ex_rt!=0 && (ex_rt==rn1 || (ex_rt==rn2 && op uses rt)). R-type, sw and beq use rt; lw and addi do not.
- Posedge update priority: rst_n low > flush > stall > normal.
  - flush=1: load a bubble; stall is forced to 0 that cycle.
  - stall=1: load a bubble. Upstream holds IF/ID, so the same instruction is re-decoded next cycle. With a bubble now in ID/EX, stall drops, so a stall lasts exactly 1 cycle.
  - Normal with id_valid=0: load a bubble.
  - Normal with id_valid=1: load the decoded instruction with ex_valid=1.
- Latency: ID/EX outputs are valid 1 cycle after the instruction is presented.
- stall_cnt increments on each posedge where stall=1. It saturates at all-ones and never wraps.
- ex_illegal is registered; it is cleared on the next cycle unless another illegal opcode is loaded.
- rn1/rn2 always follow id_instr, even while stalled or when id_valid=0.

Test Plan:
1. Reset mid-run: assert rst_n=0 between edges → all ex_* and stall_cnt read 0 before the next posedge.
2. lw $2,4($1) then add $3,$2,$4 (0x00441820):
   - stall=1 for exactly one cycle.
   - ID/EX shows a bubble (ex_valid=0, ex_regwrite=0), then the add with ex_rs=2, ex_rt=4, ex_rd=3.
   - stall_cnt=1.
3. WB bypass: wb_regwrite=1, wb_wn=5, wb_wd=0xDEADBEEF, rd1=0x11, instr rs=5 → ex_rd1=0xDEADBEEF. Repeat with wb_wn=0 → ex_rd1=0x11.
4. Flush and stall together (load-use condition true, flush=1) → bubble loaded, stall=0, stall_cnt unchanged.
5. Opcode 0x3F → ex_valid=0, ex_illegal=1 for one cycle. id_instr=0 → ex_valid=0, ex_illegal=0.
6. With STALL_CNT_W=2, force 5 stall cycles → stall_cnt reaches 3 and holds at 3.

Source files
------------

// File: rtl/id_ex_stage.sv
// Decode stage and ID/EX pipeline register: register-file addressing, WB bypass,
// control decode, load-use hazard stall, branch flush and a saturating stall counter.
module id_ex_stage #(
   parameter int STALL_CNT_W = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   id_valid,
   input  logic [31:0]            id_instr,
   input  logic [31:0]            id_pc4,
   output logic [4:0]             rn1,
   output logic [4:0]             rn2,
   input  logic [31:0]            rd1,
   input  logic [31:0]            rd2,
   input  logic                   wb_regwrite,
   input  logic [4:0]             wb_wn,
   input  logic [31:0]            wb_wd,
   input  logic                   flush,
   output logic                   stall,
   output logic                   ex_valid,
   output logic [31:0]            ex_rd1,
   output logic [31:0]            ex_rd2,
   output logic [31:0]            ex_imm,
   output logic [4:0]             ex_rs,
   output logic [4:0]             ex_rt,
   output logic [4:0]             ex_rd,
   output logic [31:0]            ex_pc4,
   output logic                   ex_regdst,
   output logic                   ex_alusrc,
   output logic                   ex_memread,
   output logic                   ex_memwrite,
   output logic                   ex_regwrite,
   output logic                   ex_memtoreg,
   output logic                   ex_branch,
   output logic [1:0]             ex_aluop,
   output logic                   ex_illegal,
   output logic [STALL_CNT_W-1:0] stall_cnt
);

   typedef struct packed {
      logic       regdst;
      logic       alusrc;
      logic       memread;
      logic       memwrite;
      logic       regwrite;
      logic       memtoreg;
      logic       branch;
      logic [1:0] aluop;
   } ctrl_t;

   typedef struct packed {
      logic        valid;
      logic [31:0] rd1;
      logic [31:0] rd2;
      logic [31:0] imm;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  rd;
      logic [31:0] pc4;
      ctrl_t       ctrl;
      logic        illegal;
   } idex_t;

   localparam logic [STALL_CNT_W-1:0] CNT_ONE = {{(STALL_CNT_W-1){1'b0}}, 1'b1};

   // A WB write to the same register this cycle wins over the stale file read; $0 reads as zero.
   function automatic logic [31:0] bypass(input logic [4:0] rn, input logic [31:0] rd,
                                          input logic wre, input logic [4:0] wn,
                                          input logic [31:0] wd);
      logic [31:0] val;
      if (wre && (wn != 5'd0) && (wn == rn)) begin
         val = wd;
      end else if (rn == 5'd0) begin
         val = 32'd0;
      end else begin
         val = rd;
      end
      return val;
   endfunction

   logic [5:0]             opcode_s;
   ctrl_t                  dec_ctrl_s;
   logic                   dec_legal_s;
   logic                   dec_illegal_s;
   logic                   uses_rt_s;
   logic                   hazard_s;
   logic                   stall_s;
   logic                   load_s;
   idex_t                  nxt_s;
   idex_t                  ex_r;
   logic [STALL_CNT_W-1:0] stall_cnt_r;

   assign opcode_s = id_instr[31:26];
   assign rn1      = id_instr[25:21];
   assign rn2      = id_instr[20:16];

   // Opcode decode into control bits, legality and whether rt is a source operand.
   always_comb begin
      dec_ctrl_s    = '0;
      dec_legal_s   = 1'b0;
      dec_illegal_s = 1'b0;
      uses_rt_s     = 1'b0;
      if (id_instr == 32'd0) begin
         dec_legal_s = 1'b0;
      end else begin
         case (opcode_s)
            6'b000000: begin
               dec_ctrl_s.regdst   = 1'b1;
               dec_ctrl_s.regwrite = 1'b1;
               dec_ctrl_s.aluop    = 2'b10;
               dec_legal_s         = 1'b1;
               uses_rt_s           = 1'b1;
            end
            6'b100011: begin
               dec_ctrl_s.alusrc   = 1'b1;
               dec_ctrl_s.memread  = 1'b1;
               dec_ctrl_s.memtoreg = 1'b1;
               dec_ctrl_s.regwrite = 1'b1;
               dec_legal_s         = 1'b1;
            end
            6'b101011: begin
               dec_ctrl_s.alusrc   = 1'b1;
               dec_ctrl_s.memwrite = 1'b1;
               dec_legal_s         = 1'b1;
               uses_rt_s           = 1'b1;
            end
            6'b000100: begin
               dec_ctrl_s.branch   = 1'b1;
               dec_ctrl_s.aluop    = 2'b01;
               dec_legal_s         = 1'b1;
               uses_rt_s           = 1'b1;
            end
            6'b001000: begin
               dec_ctrl_s.alusrc   = 1'b1;
               dec_ctrl_s.regwrite = 1'b1;
               dec_legal_s         = 1'b1;
            end
            default: begin
               dec_illegal_s = 1'b1;
            end
         endcase
      end
   end

   assign hazard_s = ex_r.valid && ex_r.ctrl.memread && (ex_r.rt != 5'd0) &&
                     ((ex_r.rt == rn1) || ((ex_r.rt == rn2) && uses_rt_s));
   // Flush discards the ID instruction anyway, so a hazard against it must not stall.
   assign stall_s  = id_valid && hazard_s && !flush;
   assign stall    = stall_s;
   assign load_s   = id_valid && !flush && !stall_s;

   // Next ID/EX contents: data fields always loaded, control only for a consumed legal instruction.
   always_comb begin
      nxt_s         = '0;
      nxt_s.rd1     = bypass(rn1, rd1, wb_regwrite, wb_wn, wb_wd);
      nxt_s.rd2     = bypass(rn2, rd2, wb_regwrite, wb_wn, wb_wd);
      nxt_s.imm     = {{16{id_instr[15]}}, id_instr[15:0]};
      nxt_s.rs      = id_instr[25:21];
      nxt_s.rt      = id_instr[20:16];
      nxt_s.rd      = id_instr[15:11];
      nxt_s.pc4     = id_pc4;
      nxt_s.illegal = load_s && dec_illegal_s;
      if (load_s && dec_legal_s) begin
         nxt_s.valid = 1'b1;
         nxt_s.ctrl  = dec_ctrl_s;
      end else begin
         nxt_s.valid = 1'b0;
         nxt_s.ctrl  = '0;
      end
   end

   // ID/EX pipeline register and saturating stall-cycle counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_r        <= '0;
         stall_cnt_r <= '0;
      end else begin
         ex_r <= nxt_s;
         if (stall_s && (stall_cnt_r != {STALL_CNT_W{1'b1}})) begin
            stall_cnt_r <= stall_cnt_r + CNT_ONE;
         end else begin
            stall_cnt_r <= stall_cnt_r;
         end
      end
   end

   assign ex_valid    = ex_r.valid;
   assign ex_rd1      = ex_r.rd1;
   assign ex_rd2      = ex_r.rd2;
   assign ex_imm      = ex_r.imm;
   assign ex_rs       = ex_r.rs;
   assign ex_rt       = ex_r.rt;
   assign ex_rd       = ex_r.rd;
   assign ex_pc4      = ex_r.pc4;
   assign ex_regdst   = ex_r.ctrl.regdst;
   assign ex_alusrc   = ex_r.ctrl.alusrc;
   assign ex_memread  = ex_r.ctrl.memread;
   assign ex_memwrite = ex_r.ctrl.memwrite;
   assign ex_regwrite = ex_r.ctrl.regwrite;
   assign ex_memtoreg = ex_r.ctrl.memtoreg;
   assign ex_branch   = ex_r.ctrl.branch;
   assign ex_aluop    = ex_r.ctrl.aluop;
   assign ex_illegal  = ex_r.illegal;
   assign stall_cnt   = stall_cnt_r;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: random and directed instruction streams checked
// against a behavioural pipeline model; a second instance has a 2-bit stall counter.
module tb_id_ex_stage;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic        id_valid = 1'b0, wb_regwrite = 1'b0, flush = 1'b0;
   logic [31:0] id_instr = 32'd0, id_pc4 = 32'd0, rd1 = 32'd0, rd2 = 32'd0, wb_wd = 32'd0;
   logic [4:0]  wb_wn = 5'd0;

   logic [4:0]  rn1, rn2, ex_rs, ex_rt, ex_rd;
   logic        stall, ex_valid, ex_regdst, ex_alusrc, ex_memread, ex_memwrite;
   logic        ex_regwrite, ex_memtoreg, ex_branch, ex_illegal;
   logic [1:0]  ex_aluop;
   logic [31:0] ex_rd1, ex_rd2, ex_imm, ex_pc4;
   logic [15:0] stall_cnt;

   logic [4:0]  s_rn1, s_rn2, s_rs, s_rt, s_rd;
   logic        s_stall, s_valid, s_regdst, s_alusrc, s_memread, s_memwrite;
   logic        s_regwrite, s_memtoreg, s_branch, s_illegal;
   logic [1:0]  s_aluop;
   logic [31:0] s_rd1, s_rd2, s_imm, s_pc4;
   logic [1:0]  s_cnt;

   id_ex_stage #(.STALL_CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_instr(id_instr), .id_pc4(id_pc4),
      .rn1(rn1), .rn2(rn2), .rd1(rd1), .rd2(rd2), .wb_regwrite(wb_regwrite), .wb_wn(wb_wn),
      .wb_wd(wb_wd), .flush(flush), .stall(stall), .ex_valid(ex_valid), .ex_rd1(ex_rd1),
      .ex_rd2(ex_rd2), .ex_imm(ex_imm), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
      .ex_pc4(ex_pc4), .ex_regdst(ex_regdst), .ex_alusrc(ex_alusrc), .ex_memread(ex_memread),
      .ex_memwrite(ex_memwrite), .ex_regwrite(ex_regwrite), .ex_memtoreg(ex_memtoreg),
      .ex_branch(ex_branch), .ex_aluop(ex_aluop), .ex_illegal(ex_illegal), .stall_cnt(stall_cnt)
   );

   id_ex_stage #(.STALL_CNT_W(2)) dut_sat (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_instr(id_instr), .id_pc4(id_pc4),
      .rn1(s_rn1), .rn2(s_rn2), .rd1(rd1), .rd2(rd2), .wb_regwrite(wb_regwrite), .wb_wn(wb_wn),
      .wb_wd(wb_wd), .flush(flush), .stall(s_stall), .ex_valid(s_valid), .ex_rd1(s_rd1),
      .ex_rd2(s_rd2), .ex_imm(s_imm), .ex_rs(s_rs), .ex_rt(s_rt), .ex_rd(s_rd),
      .ex_pc4(s_pc4), .ex_regdst(s_regdst), .ex_alusrc(s_alusrc), .ex_memread(s_memread),
      .ex_memwrite(s_memwrite), .ex_regwrite(s_regwrite), .ex_memtoreg(s_memtoreg),
      .ex_branch(s_branch), .ex_aluop(s_aluop), .ex_illegal(s_illegal), .stall_cnt(s_cnt)
   );

   typedef struct {
      bit          valid;
      logic [31:0] rd1, rd2, imm, pc4;
      logic [4:0]  rs, rt, rd;
      logic [8:0]  ctrl;      // {regdst,alusrc,memread,memwrite,regwrite,memtoreg,branch,aluop}
      bit          illegal;
      int          cnt, cnt_sat;
   } exp_t;

   exp_t sb[$];
   exp_t m;
   bit   mon_en = 1'b0;
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference decode table straight from the instruction set rules.
   task automatic mdec(input logic [31:0] ins, output logic [8:0] c, output bit ill, output bit urt);
      c = 9'd0; ill = 1'b0; urt = 1'b0;
      if (ins != 32'd0) begin
         case (ins[31:26])
            6'h00:   begin c = 9'b1_0_0_0_1_0_0_10; urt = 1'b1; end
            6'h23:   c = 9'b0_1_1_0_1_1_0_00;
            6'h2B:   begin c = 9'b0_1_0_1_0_0_0_00; urt = 1'b1; end
            6'h04:   begin c = 9'b0_0_0_0_0_0_1_01; urt = 1'b1; end
            6'h08:   c = 9'b0_1_0_0_1_0_0_00;
            default: ill = 1'b1;
         endcase
      end
   endtask

   function automatic logic [31:0] mop(input logic [4:0] r, input logic [31:0] f);
      if (wb_regwrite && wb_wn != 5'd0 && wb_wn == r) return wb_wd;
      if (r == 5'd0) return 32'd0;
      return f;
   endfunction

   function automatic logic [31:0] rand_instr();
      logic [31:0] ins;
      logic [5:0]  op;
      int          k;
      k   = $urandom_range(0, 7);
      ins = {6'd0, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 16'($urandom)};
      case (k)
         0, 1:    op = 6'h00;
         2:       op = 6'h23;
         3:       op = 6'h2B;
         4:       op = 6'h04;
         5:       op = 6'h08;
         6:       return 32'd0;
         default: begin
            op = 6'($urandom);
            if (op == 6'h00 || op == 6'h23 || op == 6'h2B || op == 6'h04 || op == 6'h08) op = 6'h3F;
         end
      endcase
      ins[31:26] = op;
      return ins;
   endfunction

   // One ID cycle: drive inputs in the low phase, check stall, predict the ID/EX result.
   task automatic cycle(input logic [31:0] ins, input bit vld, input bit fl, input bit wre,
                        input logic [4:0] wn, input logic [31:0] wd, output bit st);
      logic [8:0] c;
      bit         ill, urt, take;
      exp_t       n;
      id_instr = ins; id_valid = vld; flush = fl; wb_regwrite = wre; wb_wn = wn; wb_wd = wd;
      rd1 = $urandom; rd2 = $urandom; id_pc4 = $urandom;
      mdec(ins, c, ill, urt);
      st = vld && !fl && m.valid && m.ctrl[6] && m.rt != 5'd0 &&
           (m.rt == ins[25:21] || (m.rt == ins[20:16] && urt));
      #1;
      chk("stall", {31'd0, stall}, {31'd0, st});
      chk("stall_sat", {31'd0, s_stall}, {31'd0, st});
      chk("rn", {22'd0, rn1, rn2}, {22'd0, ins[25:21], ins[20:16]});
      take      = vld && !fl && !st;
      n         = m;
      n.valid   = take && (c != 9'd0);
      n.ctrl    = n.valid ? c : 9'd0;
      n.illegal = take && ill;
      n.rd1 = mop(ins[25:21], rd1); n.rd2 = mop(ins[20:16], rd2);
      n.imm = {{16{ins[15]}}, ins[15:0]}; n.pc4 = id_pc4;
      n.rs = ins[25:21]; n.rt = ins[20:16]; n.rd = ins[15:11];
      if (st) begin
         n.cnt     = (m.cnt < 65535) ? m.cnt + 1 : m.cnt;
         n.cnt_sat = (m.cnt_sat < 3) ? m.cnt_sat + 1 : m.cnt_sat;
      end
      m = n;
      sb.push_back(n);
      @(negedge clk);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_ctl"}, {19'd0, ex_valid, ex_regdst, ex_alusrc, ex_memread, ex_memwrite,
          ex_regwrite, ex_memtoreg, ex_branch, ex_aluop, ex_illegal}, 32'd0);
      chk({tag, "_data"}, ex_rd1 | ex_rd2 | ex_imm | ex_pc4 | {17'd0, ex_rs, ex_rt, ex_rd}, 32'd0);
      chk({tag, "_cnt"}, {14'd0, s_cnt, stall_cnt}, 32'd0);
   endtask

   // Asynchronous reset asserted mid-cycle; outputs must clear before any clock edge.
   task automatic do_reset();
      #2;
      rst_n  = 1'b0;
      mon_en = 1'b0;
      sb.delete();
      #1 chk_zero("rst_async");
      @(posedge clk);
      #1 chk_zero("rst_hold");
      @(negedge clk);
      rst_n  = 1'b1;
      m      = '{default: 0};
      mon_en = 1'b1;
   endtask

   // Monitor: one ID/EX result per clock edge, compared against the queued prediction.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (mon_en) begin
            if (sb.size() == 0) begin
               chk("sb_empty", 32'd1, 32'd0);
            end else begin
               e = sb.pop_front();
               chk("ex_valid", {31'd0, ex_valid}, {31'd0, e.valid});
               chk("ex_ctrl", {23'd0, ex_regdst, ex_alusrc, ex_memread, ex_memwrite, ex_regwrite,
                   ex_memtoreg, ex_branch, ex_aluop}, {23'd0, e.ctrl});
               chk("ex_illegal", {31'd0, ex_illegal}, {31'd0, e.illegal});
               chk("stall_cnt", {16'd0, stall_cnt}, e.cnt);
               chk("stall_cnt_sat", {30'd0, s_cnt}, e.cnt_sat);
               chk("sat_ctrl", {22'd0, s_valid, s_memread, s_regwrite, s_illegal, s_aluop, s_rt},
                   {22'd0, e.valid, e.ctrl[6], e.ctrl[4], e.illegal, e.ctrl[1:0], e.rt});
               if (e.valid) begin
                  chk("ex_rd1", ex_rd1, e.rd1);
                  chk("ex_rd2", ex_rd2, e.rd2);
                  chk("ex_imm", ex_imm, e.imm);
                  chk("ex_pc4", ex_pc4, e.pc4);
                  chk("ex_regs", {17'd0, ex_rs, ex_rt, ex_rd}, {17'd0, e.rs, e.rt, e.rd});
               end
            end
         end
      end
   end

   initial begin
      bit          st;
      bit          vld;
      logic [31:0] ins;
      m = '{default: 0};
      repeat (2) @(negedge clk);
      chk_zero("rst_init");
      rst_n  = 1'b1;
      mon_en = 1'b1;

      // load-use: lw $2,4($1) then add $3,$2,$4 held while stalled
      cycle(32'h8C22_0004, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, st);
      cycle(32'h0044_1820, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, st);
      chk("dir_stall_first", {31'd0, st}, 32'd1);
      cycle(32'h0044_1820, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, st);
      chk("dir_stall_second", {31'd0, st}, 32'd0);
      chk("dir_add_fields", {17'd0, ex_rs, ex_rt, ex_rd}, {17'd0, 5'd2, 5'd4, 5'd3});

      // WB bypass onto rs=5, then the same with wb_wn=0
      cycle(32'h00A6_0820, 1'b1, 1'b0, 1'b1, 5'd5, 32'hDEAD_BEEF, st);
      chk("dir_bypass", ex_rd1, 32'hDEAD_BEEF);
      cycle(32'h00A6_0820, 1'b1, 1'b0, 1'b1, 5'd0, 32'hDEAD_BEEF, st);

      // flush while a load-use hazard is pending
      cycle(32'h8C22_0004, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, st);
      cycle(32'h0044_1820, 1'b1, 1'b1, 1'b0, 5'd0, 32'd0, st);
      chk("dir_flush_nostall", {31'd0, st}, 32'd0);

      // illegal opcode, then nop, then a legal addi
      cycle(32'hFC00_0000, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, st);
      cycle(32'h0000_0000, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, st);
      cycle(32'h2003_FFFF, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, st);

      // five more load-use stalls to push the 2-bit counter into saturation
      repeat (5) begin
         cycle(32'h8C22_0004, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, st);
         cycle(32'h0044_1820, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, st);
         cycle(32'h0044_1820, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, st);
      end
      chk("dir_sat_hold", {30'd0, s_cnt}, 32'd3);

      st  = 1'b0;
      vld = 1'b1;
      ins = 32'd0;
      for (int i = 0; i < 600; i++) begin
         if (!st) begin
            ins = rand_instr();
            vld = ($urandom_range(0, 7) != 0);
         end
         cycle(ins, vld, ($urandom_range(0, 11) == 0), 1'($urandom), 5'($urandom_range(0, 7)),
               $urandom, st);
         if (i == 300) begin
            do_reset();
            st = 1'b0;
         end
      end

      #3;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
